// File: rtl/vc_pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vc_pop_arbiter
// Description : Pop scheduler for the two virtual-channel FIFOs (VC0, VC1)
//               that feed the shared output mux. VC0 has strict priority;
//               a starvation counter forces one VC1 grant after
//               MAX_VC0_BURST back-to-back VC0 grants while VC1 was waiting.
//               At most one pop per cycle. A 1-entry FIFO is never popped
//               on back-to-back cycles, because its flags lag the pop that
//               is still in flight.
// Ports       : clk, reset_L (async, active-low)
//               arb_en                            - arbitration enable
//               vc0_empty / vc0_almost_empty      - VC0 FIFO flags
//               vc1_empty / vc1_almost_empty      - VC1 FIFO flags
//               d0_almost_full / d1_almost_full   - downstream back-pressure
//               pop_delay_vc0 / pop_delay_vc1     - registered pops
//               arb_state                         - 0 IDLE,1 GRANT0,2 GRANT1,3 STALL
//               With ARB_POP_COUNT_EN defined:
//               clear_counts                      - synchronous counter clear
//               pop_count_vc0 / pop_count_vc1     - wrapping pop counters
// Option      : `define ARB_POP_COUNT_EN adds the pop counters
// Revision    : 1.0 - initial release
// ============================================================================
module vc_pop_arbiter #(
    parameter int MAX_VC0_BURST = 4,
    parameter int CNT_W         = 3,
    parameter int PCNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              arb_en,
    input  logic              vc0_empty,
    input  logic              vc0_almost_empty,
    input  logic              vc1_empty,
    input  logic              vc1_almost_empty,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    output logic              pop_delay_vc0,
    output logic              pop_delay_vc1,
    output logic [1:0]        arb_state
`ifdef ARB_POP_COUNT_EN
    ,
    input  logic              clear_counts,
    output logic [PCNT_W-1:0] pop_count_vc0,
    output logic [PCNT_W-1:0] pop_count_vc1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_STALL  = 2'd3
    } arb_state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VC0_BURST);

    // Elaboration-time guard on the parameter ranges.
    if (MAX_VC0_BURST < 1 || MAX_VC0_BURST > (1 << CNT_W) - 1 || PCNT_W < 1) begin : g_param_check
        $error("vc_pop_arbiter: parameter out of range");
    end

    arb_state_t       state_q, state_d;
    logic             pop0_q, pop0_d;
    logic             pop1_q, pop1_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    logic elig0;
    logic elig1;
    logic stall;

    always_comb begin
        // A FIFO showing almost_empty while our pop to it is still in
        // flight may already be drained; skip it for this decision.
        elig0 = ~vc0_empty & ~(pop0_q & vc0_almost_empty);
        elig1 = ~vc1_empty & ~(pop1_q & vc1_almost_empty);
        stall = d0_almost_full | d1_almost_full;

        state_d      = ST_IDLE;
        starve_cnt_d = starve_cnt_q;

        if (!arb_en) begin
            state_d = ST_IDLE;
        end else if (stall && (!vc0_empty || !vc1_empty)) begin
            state_d = ST_STALL;
        end else if (elig0 && elig1) begin
            state_d = (starve_cnt_q == MAX_CNT) ? ST_GRANT1 : ST_GRANT0;
        end else if (elig0) begin
            state_d = ST_GRANT0;
        end else if (elig1) begin
            state_d = ST_GRANT1;
        end else begin
            state_d = ST_IDLE;
        end

        // Counter is frozen while disabled or stalled, so a stall does not
        // reset the fairness window.
        if (arb_en && (state_d != ST_STALL)) begin
            if ((state_d == ST_GRANT1) || !elig1) begin
                starve_cnt_d = '0;
            end else if ((state_d == ST_GRANT0) && (starve_cnt_q != MAX_CNT)) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end

        pop0_d = (state_d == ST_GRANT0);
        pop1_d = (state_d == ST_GRANT1);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= ST_IDLE;
            pop0_q       <= 1'b0;
            pop1_q       <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pop0_q       <= pop0_d;
            pop1_q       <= pop1_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign pop_delay_vc0 = pop0_q;
    assign pop_delay_vc1 = pop1_q;
    assign arb_state     = state_q;

`ifdef ARB_POP_COUNT_EN
    logic [PCNT_W-1:0] pcnt0_q, pcnt0_d;
    logic [PCNT_W-1:0] pcnt1_q, pcnt1_d;

    always_comb begin
        pcnt0_d = pcnt0_q;
        pcnt1_d = pcnt1_q;
        if (clear_counts) begin
            pcnt0_d = '0;
            pcnt1_d = '0;
        end else begin
            if (pop0_q) pcnt0_d = pcnt0_q + PCNT_W'(1);
            if (pop1_q) pcnt1_d = pcnt1_q + PCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pcnt0_q <= '0;
            pcnt1_q <= '0;
        end else begin
            pcnt0_q <= pcnt0_d;
            pcnt1_q <= pcnt1_d;
        end
    end

    assign pop_count_vc0 = pcnt0_q;
    assign pop_count_vc1 = pcnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vc_pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_pop_arbiter
// Description : Self-checking bench for vc_pop_arbiter. A behavioural model
//               tracks the expected pops/state; a negedge process compares
//               the DUT against it every cycle. Directed scenarios pin the
//               model with literal expectations, followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_pop_arbiter;

    localparam int MAXB   = 4;
    localparam int PCNT_W = 8;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    logic arb_en = 1'b0;
    logic vc0_empty = 1'b1, vc0_almost_empty = 1'b1;
    logic vc1_empty = 1'b1, vc1_almost_empty = 1'b1;
    logic d0_almost_full = 1'b0, d1_almost_full = 1'b0;
    logic pop_delay_vc0, pop_delay_vc1;
    logic [1:0] arb_state;
`ifdef ARB_POP_COUNT_EN
    logic clear_counts = 1'b0;
    logic [PCNT_W-1:0] pop_count_vc0, pop_count_vc1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vc_pop_arbiter #(.MAX_VC0_BURST(MAXB), .CNT_W(3), .PCNT_W(PCNT_W)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .arb_en           (arb_en),
        .vc0_empty        (vc0_empty),
        .vc0_almost_empty (vc0_almost_empty),
        .vc1_empty        (vc1_empty),
        .vc1_almost_empty (vc1_almost_empty),
        .d0_almost_full   (d0_almost_full),
        .d1_almost_full   (d1_almost_full),
        .pop_delay_vc0    (pop_delay_vc0),
        .pop_delay_vc1    (pop_delay_vc1),
        .arb_state        (arb_state)
`ifdef ARB_POP_COUNT_EN
        ,
        .clear_counts     (clear_counts),
        .pop_count_vc0    (pop_count_vc0),
        .pop_count_vc1    (pop_count_vc1)
`endif
    );

    // ---------------- behavioural model ----------------
    // m_grant: which VC was granted last decision (0 none, 1 VC0, 2 VC1)
    // m_mode : reported state code; m_burst: VC0 grants while VC1 waited
    int m_grant = 0;
    int m_mode  = 0;
    int m_burst = 0;
    int m_pc0   = 0;
    int m_pc1   = 0;

    always @(posedge clk or negedge reset_L) begin : model
        bit  ok0, ok1, has_data, bp;
        int  g;
        if (!reset_L) begin
            m_grant = 0; m_mode = 0; m_burst = 0; m_pc0 = 0; m_pc1 = 0;
        end else begin
`ifdef ARB_POP_COUNT_EN
            if (clear_counts) begin m_pc0 = 0; m_pc1 = 0; end
            else begin
                if (m_grant == 1) m_pc0 = (m_pc0 + 1) % (1 << PCNT_W);
                if (m_grant == 2) m_pc1 = (m_pc1 + 1) % (1 << PCNT_W);
            end
`endif
            ok0 = !vc0_empty && !(m_grant == 1 && vc0_almost_empty);
            ok1 = !vc1_empty && !(m_grant == 2 && vc1_almost_empty);
            has_data = !vc0_empty || !vc1_empty;
            bp = d0_almost_full || d1_almost_full;
            if (!arb_en)              begin m_mode = 0; g = 0; end
            else if (bp && has_data)  begin m_mode = 3; g = 0; end
            else begin
                if (ok0 && ok1) g = (m_burst >= MAXB) ? 2 : 1;
                else if (ok0)   g = 1;
                else if (ok1)   g = 2;
                else            g = 0;
                m_mode = g;
                if (g == 2 || !ok1) m_burst = 0;
                else if (g == 1)    m_burst = (m_burst + 1 > MAXB) ? MAXB : m_burst + 1;
            end
            m_grant = g;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_pop0",  {31'd0, pop_delay_vc0}, (m_grant == 1) ? 32'd1 : 32'd0);
        chk("model_pop1",  {31'd0, pop_delay_vc1}, (m_grant == 2) ? 32'd1 : 32'd0);
        chk("model_state", {30'd0, arb_state},     32'(m_mode));
`ifdef ARB_POP_COUNT_EN
        chk("model_pcnt0", 32'(pop_count_vc0), 32'(m_pc0));
        chk("model_pcnt1", 32'(pop_count_vc1), 32'(m_pc1));
`endif
    end

    task automatic set_in(input bit en, input bit e0, input bit ae0, input bit e1,
                          input bit ae1, input bit af0, input bit af1);
        arb_en = en; vc0_empty = e0; vc0_almost_empty = ae0;
        vc1_empty = e1; vc1_almost_empty = ae1;
        d0_almost_full = af0; d1_almost_full = af1;
    endtask

    // one clock: inputs already applied at a negedge, sample at the next negedge
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic exp_out(input string nm, input int st, input bit p0, input bit p1);
        chk({nm, "_state"}, {30'd0, arb_state}, 32'(st));
        chk({nm, "_pop0"},  {31'd0, pop_delay_vc0}, {31'd0, p0});
        chk({nm, "_pop1"},  {31'd0, pop_delay_vc1}, {31'd0, p1});
    endtask

    int starve_seq [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    initial begin
        // reset state
        set_in(1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        exp_out("reset", 0, 0, 0);
        reset_L = 1'b1;

        // starvation guard: both deep
        for (int i = 0; i < 10; i++) begin
            cyc();
            exp_out("starve", starve_seq[i], starve_seq[i] == 1, starve_seq[i] == 2);
        end

        // back-pressure: two VC0 grants, 3-cycle stall, burst count must survive
        cyc(); cyc();
        set_in(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            exp_out("stall", 3, 0, 0);
        end
        set_in(1, 0, 0, 0, 0, 0, 0);
        cyc(); exp_out("resume0", 1, 1, 0);
        cyc(); exp_out("resume1", 1, 1, 0);
        cyc(); exp_out("resume2", 2, 0, 1);

        // arb_en low with data present
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            exp_out("disabled", 0, 0, 0);
        end

        // VC1-only traffic
        set_in(1, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            exp_out("vc1only", 2, 0, 1);
        end

        // single-entry VC0
        set_in(1, 0, 1, 1, 1, 0, 0);
        cyc(); exp_out("single0", 1, 1, 0);
        cyc(); exp_out("single1", 0, 0, 0);
        set_in(1, 1, 1, 1, 1, 0, 0);
        cyc(); exp_out("single2", 0, 0, 0);

        // asynchronous reset mid-grant
        set_in(1, 0, 0, 0, 0, 0, 0);
        cyc(); exp_out("pre_rst", 1, 1, 0);
        #2 reset_L = 1'b0;
        #1 exp_out("async_rst", 0, 0, 0);
        @(negedge clk);
        reset_L = 1'b1;
        cyc(); exp_out("post_rst", 1, 1, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit e0, e1;
            e0 = ($urandom_range(0, 3) == 0);
            e1 = ($urandom_range(0, 3) == 0);
            set_in($urandom_range(0, 9) != 0,
                   e0, e0 | ($urandom_range(0, 2) == 0),
                   e1, e1 | ($urandom_range(0, 2) == 0),
                   $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            cyc();
            chk("one_hot", {31'd0, pop_delay_vc0 & pop_delay_vc1}, 32'd0);
        end

`ifdef ARB_POP_COUNT_EN
        reset_L = 1'b0;
        set_in(1, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        reset_L = 1'b1;
        repeat (261) cyc();
        chk("pcnt_wrap", 32'(pop_count_vc0), 32'd4);
        clear_counts = 1'b1;
        cyc();
        clear_counts = 1'b0;
        chk("pcnt_clear", 32'(pop_count_vc0), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
